ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch stage that feeds `idu_dec`. It owns the architectural fetch PC and issues single-outstanding word reads on the instruction bus. Returned instructions are buffered with their PCs in a small FIFO, and the FIFO head is presented to the decoder as `inst_o`/`pc_o`. The stage accepts jump/branch redirects from the BPU/EXU, flushes stale state, and discards in-flight responses.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `FIFO_DEPTH`, 2: instruction buffer entries; must be a power of two, ≥ 2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_` in 1: asynchronous, active-low reset.
- `ibus_req_` out 1: active-low fetch request.
- `ibus_addr` out `ADDR_LEN`: fetch address, word aligned.
- `ibus_gnt` in 1: request accepted this cycle; meaningful only while `ibus_req_`=0.
- `ibus_rvalid` in 1: read data valid; arrives at least 1 cycle after `gnt`.
- `ibus_rdata` in `ISA_LEN`: instruction word.
- `redir_` in 1: active-low redirect strobe, one cycle.
- `redir_pc` in `ADDR_LEN`: redirect target; bits [1:0] are ignored and forced to 0.
- `stall_` in 1: active-low decoder stall; holds the FIFO head.
- `inst_o` out `ISA_LEN`: instruction to `idu_dec`.
- `pc_o` out `ADDR_LEN`: PC of `inst_o`.
- `inst_valid_o` out 1: `inst_o`/`pc_o` are valid.

## Operation
- The FSM has three states: REQ, WAIT, DROP. Reset enters REQ with `fetch_pc`=`RESET_PC`, an empty FIFO, `ibus_req_`=1, `inst_o`=NOP (32'h0000_0013), `pc_o`=0, `inst_valid_o`=0.
- **REQ:**
  - `ibus_req_`=0 when FIFO count < `FIFO_DEPTH`; `ibus_addr`=`fetch_pc`.
  - On `gnt`: `fetch_pc` += `PC_INC` (4) and the state moves to WAIT.
  - The granted PC is latched as `req_pc`.
- **WAIT:**
  - `ibus_req_`=1.
  - On `rvalid`: push {`req_pc`, `ibus_rdata`} into the FIFO and return to REQ.
- **DROP:**
  - `ibus_req_`=1.
  - On `rvalid`: discard the data and return to REQ.
- **Redirect** (`redir_`=0), which takes priority over every other event in the same cycle:
  - Always: `fetch_pc` ← `{redir_pc[31:2],2'b00}`; FIFO flushed; `inst_valid_o` forced to 0 combinationally that cycle.
  - REQ without `gnt`: request withdrawn (the bus permits withdrawal before grant); stay in REQ.
  - REQ with `gnt`: go to DROP.
  - WAIT without `rvalid`: go to DROP.
  - WAIT with `rvalid`: the response is discarded; go to REQ.
  - DROP: stay in DROP, or go to REQ if `rvalid`.
- **Output:**
  - `inst_valid_o` = FIFO non-empty and not redirect.
  - `inst_o`/`pc_o` come from the FIFO head; when empty, `inst_o`=NOP and `pc_o`=0.
  - Pop when `inst_valid_o`=1 and `stall_`=1.
- Push and pop in the same cycle leave the count unchanged. A push into a full FIFO cannot occur because issue is gated on count.
- `fetch_pc` wraps modulo 2^32 (0xFFFF_FFFC+4 → 0).

## Timing
- Best case: `gnt` in cycle N, `rvalid` in N+1, push on the N+1 edge, `inst_valid_o`=1 in N+2.
- Next request is issued in N+2, so peak throughput is 1 instruction per 2 cycles.
- Redirect in cycle N: first request to the new target in N+1 (from REQ), or in the cycle after the stale `rvalid` is dropped.
- Reset release: first `ibus_req_`=0 in the first clock after deassertion.
- Asynchronous reset mid-transaction returns to the reset values immediately. A late `rvalid` arriving in REQ is ignored.

## Structure
- `core.h` holds `ISA_LEN`, `ADDR_LEN`, `PC_INC`, `ENABLE_`/`DISABLE_`, and the new constants `INST_NOP` (32'h0000_0013) and `RESET_PC_DEFAULT`.
- The FIFO is a sub-module `ifu_fifo`: synchronous, parameterised width/depth, with push, pop, flush, count, empty and full. Flush has priority over push.
- The FSM and `fetch_pc` live in `ifu_fetch`.

## Test plan
- Reset, `gnt` immediate, `rvalid`+1 returning 0x00500093 → `ibus_addr`=0x0, then `inst_o`=0x00500093, `pc_o`=0x0, `inst_valid_o`=1 two cycles after `gnt`; next `ibus_addr`=0x4.
- `stall_`=0 held for 10 cycles, FIFO_DEPTH=2 → exactly 2 pushes, then `ibus_req_`=1 while full; the head holds. Releasing `stall_` → pops on consecutive cycles.
- `redir_`=0 with `redir_pc`=0x100 while in WAIT, `rvalid` arriving 2 cycles later → the response is dropped, FIFO empty, next `ibus_addr`=0x100, and the first valid `pc_o` is 0x100.
- Redirect coincident with `rvalid` in WAIT → nothing pushed; request to the target issued the next cycle.
- Redirect with `redir_pc`=0x203 while `gnt`=0 in REQ → the request is withdrawn and re-issued next cycle with `ibus_addr`=0x200.
- `RESET_PC`=0xFFFF_FFFC, two fetches → `ibus_addr` sequence 0xFFFF_FFFC then 0x0; `rst_` asserted mid-WAIT → outputs return to their reset values.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package ifu_fetch_pkg;

    localparam int ISA_LEN  = 32;
    localparam int ADDR_LEN = 32;

    localparam logic [ADDR_LEN-1:0] PC_INC           = 32'd4;
    localparam logic [ISA_LEN-1:0]  INST_NOP         = 32'h0000_0013;
    localparam logic [ADDR_LEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Active-low strobe levels used across the core.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_DROP
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_LEN-1:0] pc;
        logic [ISA_LEN-1:0]  inst;
    } fetch_entry_t;

    function automatic logic [ADDR_LEN-1:0] word_align(input logic [ADDR_LEN-1:0] addr);
        return addr & ~ADDR_LEN'(3);
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs; flush wins over push.
module ifu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage is not reset; validity is tracked by count, so only the
    // pointers and count need a reset value.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: owns fetch_pc, issues single-outstanding instruction reads,
// buffers responses and handles redirects by flushing and dropping stale data.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [ADDR_LEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                  FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_,
    output logic                ibus_req_,
    output logic [ADDR_LEN-1:0] ibus_addr,
    input  logic                ibus_gnt,
    input  logic                ibus_rvalid,
    input  logic [ISA_LEN-1:0]  ibus_rdata,
    input  logic                redir_,
    input  logic [ADDR_LEN-1:0] redir_pc,
    input  logic                stall_,
    output logic [ISA_LEN-1:0]  inst_o,
    output logic [ADDR_LEN-1:0] pc_o,
    output logic                inst_valid_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e        state;
    logic [ADDR_LEN-1:0] fetch_pc;
    logic [ADDR_LEN-1:0] req_pc;
    logic                fetch_en;
    logic                redir;
    logic                issue;
    logic                granted;
    logic                push;
    logic                pop;
    fetch_entry_t        wr_entry;
    fetch_entry_t        head;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_empty;
    logic                fifo_full;

    assign redir    = (redir_ == ENABLE_);
    // fetch_en holds the request off for the reset cycle and the one after release.
    assign issue    = fetch_en && (state == ST_REQ) && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign granted  = issue && ibus_gnt;
    assign push     = (state == ST_WAIT) && ibus_rvalid && !redir;
    assign wr_entry = '{pc: req_pc, inst: ibus_rdata};

    assign ibus_req_    = issue ? ENABLE_ : DISABLE_;
    assign ibus_addr    = fetch_pc;
    assign inst_valid_o = !fifo_empty && !redir;
    assign pop          = inst_valid_o && (stall_ == DISABLE_);
    assign inst_o       = fifo_empty ? INST_NOP : head.inst;
    assign pc_o         = fifo_empty ? '0 : head.pc;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= ST_REQ;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            fetch_en <= 1'b0;
        end else begin
            fetch_en <= 1'b1;
            if (redir) begin
                fetch_pc <= word_align(redir_pc);
            end else if (granted) begin
                fetch_pc <= fetch_pc + PC_INC;
            end
            if (granted) req_pc <= fetch_pc;

            case (state)
                // A grant in the redirect cycle leaves a stale response in flight.
                ST_REQ:  if (granted) state <= redir ? ST_DROP : ST_WAIT;
                ST_WAIT: begin
                    if (ibus_rvalid)  state <= ST_REQ;
                    else if (redir)   state <= ST_DROP;
                end
                ST_DROP: if (ibus_rvalid) state <= ST_REQ;
                default: state <= ST_REQ;
            endcase
        end
    end

    ifu_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .wdata (wr_entry),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always @(posedge clk) begin
        if (rst_ && push) assert (!fifo_full);
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: reset, basic fetch, stall backpressure,
// redirects in each state, PC wrap and asynchronous reset mid-transaction.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_;
    logic        ibus_gnt, ibus_rvalid, redir_, stall_;
    logic [31:0] ibus_rdata, redir_pc;

    logic        ibus_req_, inst_valid_o;
    logic [31:0] ibus_addr, inst_o, pc_o;
    logic        w_req_, w_valid;
    logic [31:0] w_addr, w_inst, w_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifu_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_(rst_), .ibus_req_(ibus_req_), .ibus_addr(ibus_addr),
        .ibus_gnt(ibus_gnt), .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
        .redir_(redir_), .redir_pc(redir_pc), .stall_(stall_),
        .inst_o(inst_o), .pc_o(pc_o), .inst_valid_o(inst_valid_o)
    );

    ifu_fetch #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_w (
        .clk(clk), .rst_(rst_), .ibus_req_(w_req_), .ibus_addr(w_addr),
        .ibus_gnt(ibus_gnt), .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
        .redir_(redir_), .redir_pc(redir_pc), .stall_(stall_),
        .inst_o(w_inst), .pc_o(w_pc), .inst_valid_o(w_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0;
        redir_ = 1'b1; redir_pc = '0; stall_ = 1'b1;
    endtask

    // Leaves the bench in the first cycle with the request asserted.
    task automatic do_reset();
        idle_inputs();
        rst_ = 1'b0;
        step(); step();
        rst_ = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ = 1'b0;
        step();
        @(negedge clk);
        checks++; if (ibus_req_ !== 1'b1) begin errors++; $display("FAIL reset_req: got %b expected 1", ibus_req_); end
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid_o); end
        checks++; if (inst_o !== 32'h0000_0013) begin errors++; $display("FAIL reset_inst: got %h expected 00000013", inst_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", pc_o); end
        checks++; if (ibus_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", ibus_addr); end
        checks++; if (w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_addr_w: got %h expected fffffffc", w_addr); end
        step();
        rst_ = 1'b1;
        @(negedge clk);
        checks++; if (ibus_req_ !== 1'b1) begin errors++; $display("FAIL release_req_hold: got %b expected 1", ibus_req_); end
        step();
        @(negedge clk);
        checks++; if (ibus_req_ !== 1'b0) begin errors++; $display("FAIL release_req: got %b expected 0", ibus_req_); end
    endtask

    task automatic test_basic();
        do_reset();
        ibus_gnt = 1'b1;
        @(negedge clk);
        checks++; if (ibus_addr !== 32'h0) begin errors++; $display("FAIL basic_addr0: got %h expected 00000000", ibus_addr); end
        step();
        ibus_gnt = 1'b0; ibus_rvalid = 1'b1; ibus_rdata = 32'h0050_0093;
        @(negedge clk);
        checks++; if (ibus_req_ !== 1'b1) begin errors++; $display("FAIL basic_wait_req: got %b expected 1", ibus_req_); end
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", inst_valid_o); end
        step();
        ibus_rvalid = 1'b0;
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", inst_valid_o); end
        checks++; if (inst_o !== 32'h0050_0093) begin errors++; $display("FAIL basic_inst: got %h expected 00500093", inst_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL basic_pc: got %h expected 00000000", pc_o); end
        checks++; if (ibus_addr !== 32'h4 || ibus_req_ !== 1'b0) begin errors++; $display("FAIL basic_next_addr: got %h/%b expected 00000004/0", ibus_addr, ibus_req_); end
        step();
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL basic_popped: got %b expected 0", inst_valid_o); end
    endtask

    task automatic test_stall();
        logic        pend;
        logic [31:0] pend_addr;
        int          grants;
        do_reset();
        stall_ = 1'b0; pend = 1'b0; pend_addr = '0; grants = 0;
        for (int i = 0; i < 10; i++) begin
            ibus_rvalid = pend;
            ibus_rdata  = pend_addr ^ 32'hA5A5_0000;
            ibus_gnt    = (ibus_req_ == 1'b0);
            if (ibus_gnt) begin
                grants++; pend = 1'b1; pend_addr = ibus_addr;
            end else begin
                pend = 1'b0;
            end
            @(negedge clk);
            step();
        end
        ibus_gnt = 1'b0; ibus_rvalid = 1'b0;
        @(negedge clk);
        checks++; if (grants != 2) begin errors++; $display("FAIL stall_grants: got %0d expected 2", grants); end
        checks++; if (ibus_req_ !== 1'b1) begin errors++; $display("FAIL stall_full_req: got %b expected 1", ibus_req_); end
        checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h0) begin errors++; $display("FAIL stall_head: got %b/%h expected 1/00000000", inst_valid_o, pc_o); end
        checks++; if (inst_o !== 32'hA5A5_0000) begin errors++; $display("FAIL stall_head_inst: got %h expected a5a50000", inst_o); end
        step();
        stall_ = 1'b1;
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h0) begin errors++; $display("FAIL stall_pop0: got %b/%h expected 1/00000000", inst_valid_o, pc_o); end
        step();
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h4) begin errors++; $display("FAIL stall_pop1: got %b/%h expected 1/00000004", inst_valid_o, pc_o); end
        checks++; if (inst_o !== 32'hA5A5_0004) begin errors++; $display("FAIL stall_pop1_inst: got %h expected a5a50004", inst_o); end
        checks++; if (ibus_req_ !== 1'b0 || ibus_addr !== 32'h8) begin errors++; $display("FAIL stall_reissue: got %b/%h expected 0/00000008", ibus_req_, ibus_addr); end
        step();
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL stall_drained: got %b expected 0", inst_valid_o); end
    endtask

    task automatic test_redir_wait();
        do_reset();
        ibus_gnt = 1'b1;
        step();
        ibus_gnt = 1'b0; redir_ = 1'b0; redir_pc = 32'h100;
        @(negedge clk);
        checks++; if (ibus_req_ !== 1'b1 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL rw_redir_cycle: got %b/%b expected 1/0", ibus_req_, inst_valid_o); end
        step();
        redir_ = 1'b1;
        step();
        ibus_rvalid = 1'b1; ibus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (ibus_req_ !== 1'b1) begin errors++; $display("FAIL rw_drop_req: got %b expected 1", ibus_req_); end
        step();
        ibus_rvalid = 1'b0; ibus_gnt = 1'b1;
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rw_dropped: got %b expected 0", inst_valid_o); end
        checks++; if (ibus_req_ !== 1'b0 || ibus_addr !== 32'h100) begin errors++; $display("FAIL rw_target: got %b/%h expected 0/00000100", ibus_req_, ibus_addr); end
        step();
        ibus_gnt = 1'b0; ibus_rvalid = 1'b1; ibus_rdata = 32'h00A0_0113;
        step();
        ibus_rvalid = 1'b0;
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h100 || inst_o !== 32'h00A0_0113) begin errors++; $display("FAIL rw_first_valid: got %b/%h/%h expected 1/00000100/00a00113", inst_valid_o, pc_o, inst_o); end
    endtask

    task automatic test_redir_rvalid();
        do_reset();
        ibus_gnt = 1'b1;
        step();
        ibus_gnt = 1'b0; ibus_rvalid = 1'b1; ibus_rdata = 32'h1111_1111;
        redir_ = 1'b0; redir_pc = 32'h40;
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rr_valid: got %b expected 0", inst_valid_o); end
        step();
        ibus_rvalid = 1'b0; redir_ = 1'b1;
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0000_0013) begin errors++; $display("FAIL rr_not_pushed: got %b/%h expected 0/00000013", inst_valid_o, inst_o); end
        checks++; if (ibus_req_ !== 1'b0 || ibus_addr !== 32'h40) begin errors++; $display("FAIL rr_target: got %b/%h expected 0/00000040", ibus_req_, ibus_addr); end
    endtask

    task automatic test_redir_req();
        do_reset();
        redir_ = 1'b0; redir_pc = 32'h203;
        step();
        redir_ = 1'b1; ibus_gnt = 1'b1;
        @(negedge clk);
        checks++; if (ibus_req_ !== 1'b0 || ibus_addr !== 32'h200) begin errors++; $display("FAIL rq_target: got %b/%h expected 0/00000200", ibus_req_, ibus_addr); end
        step();
        ibus_gnt = 1'b0; ibus_rvalid = 1'b1; ibus_rdata = 32'h2222_2222;
        step();
        ibus_rvalid = 1'b0;
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h200) begin errors++; $display("FAIL rq_first_valid: got %b/%h expected 1/00000200", inst_valid_o, pc_o); end
    endtask

    task automatic test_redir_flush();
        do_reset();
        ibus_gnt = 1'b1;
        step();
        ibus_gnt = 1'b0; ibus_rvalid = 1'b1; ibus_rdata = 32'h3333_3333;
        step();
        ibus_rvalid = 1'b0; stall_ = 1'b0; redir_ = 1'b0; redir_pc = 32'h300;
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rf_forced: got %b expected 0", inst_valid_o); end
        step();
        redir_ = 1'b1; stall_ = 1'b1;
        @(negedge clk);
        checks++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0000_0013 || pc_o !== 32'h0) begin errors++; $display("FAIL rf_flushed: got %b/%h/%h expected 0/00000013/00000000", inst_valid_o, inst_o, pc_o); end
        checks++; if (ibus_addr !== 32'h300) begin errors++; $display("FAIL rf_addr: got %h expected 00000300", ibus_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        ibus_gnt = 1'b1;
        @(negedge clk);
        checks++; if (w_req_ !== 1'b0 || w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %b/%h expected 0/fffffffc", w_req_, w_addr); end
        step();
        ibus_gnt = 1'b0; ibus_rvalid = 1'b1; ibus_rdata = 32'h4444_4444;
        step();
        ibus_rvalid = 1'b0; stall_ = 1'b0; ibus_gnt = 1'b1;
        @(negedge clk);
        checks++; if (w_req_ !== 1'b0 || w_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1: got %b/%h expected 0/00000000", w_req_, w_addr); end
        checks++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_head: got %b/%h expected 1/fffffffc", w_valid, w_pc); end
        step();
        ibus_gnt = 1'b0;
        #1 rst_ = 1'b0;
        #1;
        checks++; if (w_req_ !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_rst_bus: got %b/%h expected 1/fffffffc", w_req_, w_addr); end
        checks++; if (w_valid !== 1'b0 || w_inst !== 32'h0000_0013 || w_pc !== 32'h0) begin errors++; $display("FAIL wrap_rst_out: got %b/%h/%h expected 0/00000013/00000000", w_valid, w_inst, w_pc); end
        step();
        idle_inputs();
        rst_ = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redir_wait();
        test_redir_rvalid();
        test_redir_req();
        test_redir_flush();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
